// File: rtl/kanagawa_event_drain_pkg.sv
// Shared constants and helpers for the event batch drain.
// Provides the default batch size and idle timeout, and the function
// that sizes a batch count so it can hold 0..max_batch.
package kanagawa_event_drain_pkg;

  localparam int DEF_MAX_BATCH = 4;
  localparam int DEF_TIMEOUT   = 8;

  // Bits needed to represent a count from 0 up to and including max_batch.
  function automatic int count_width(input int max_batch);
    return $clog2(max_batch + 1);
  endfunction

endpackage

// File: rtl/kanagawa_event_batch_drain_if.sv
// Handshake bundle between the batch drain, the upstream event counter
// and the batch consumer. The drain uses the master view; the
// surrounding logic (or a bench) uses the slave view.
interface kanagawa_event_batch_drain_if
  import kanagawa_event_drain_pkg::*;
#(
  parameter int CW = count_width(DEF_MAX_BATCH)
);
  logic          empty_in;
  logic          rdreq_out;
  logic          flush_in;
  logic          valid_out;
  logic [CW-1:0] count_out;
  logic          ready_in;
  logic          busy_out;

  modport master (
    input  empty_in, flush_in, ready_in,
    output rdreq_out, valid_out, count_out, busy_out
  );

  modport slave (
    output empty_in, flush_in, ready_in,
    input  rdreq_out, valid_out, count_out, busy_out
  );
endinterface

// File: rtl/kanagawa_idle_timer.sv
// Saturating idle counter. Counts cycles while en_in is high, clears on
// clr_in (clear wins), holds at TIMEOUT, and raises hit_out while the
// count sits at TIMEOUT. hit_out is taken straight from the register.
module kanagawa_idle_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_in,
  input  logic en_in,
  output logic hit_out
);
  localparam int            W     = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  LIMIT = W'(TIMEOUT);

  logic [W-1:0] idle_cnt_q;
  logic [W-1:0] idle_cnt_d;

  // Next idle count: clear, saturating increment, or hold.
  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (clr_in) begin
      idle_cnt_d = '0;
    end else if (en_in && (idle_cnt_q != LIMIT)) begin
      idle_cnt_d = idle_cnt_q + W'(1);
    end
  end

  // Idle count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign hit_out = (idle_cnt_q == LIMIT);
endmodule

// File: rtl/kanagawa_event_batch_drain.sv
// Event batch drain: pops events from a zero-bit FIFO (empty flag +
// read request), groups them into batches of up to MAX_BATCH and hands
// each batch to the consumer as a single count on a valid/ready register.
// A partial batch leaves on flush_in (remembered if the output register
// is busy) or, when KANAGAWA_EVENT_BATCH_DRAIN_TIMEOUT_EN is defined,
// after TIMEOUT idle cycles.
module kanagawa_event_batch_drain
  import kanagawa_event_drain_pkg::*;
#(
  parameter  int MAX_BATCH   = DEF_MAX_BATCH,
  parameter  int TIMEOUT     = DEF_TIMEOUT,
  localparam int COUNT_WIDTH = count_width(MAX_BATCH)
) (
  input  logic                          clk,
  input  logic                          rst,
  kanagawa_event_batch_drain_if.master  bus
);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT = COUNT_WIDTH'(MAX_BATCH);

  if ((MAX_BATCH < 1) || (TIMEOUT < 1)) begin : g_bad_param
    $error("kanagawa_event_batch_drain: MAX_BATCH and TIMEOUT must be >= 1");
  end

  logic [COUNT_WIDTH-1:0] accum_q, accum_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   valid_q, valid_d;
  logic                   flush_pend_q, flush_pend_d;

  logic full;
  logic out_free;
  logic pop;
  logic timeout_hit;
  logic flush_cond;
  logic transfer;

  assign full     = (accum_q == MAX_CNT);
  assign out_free = !valid_q || bus.ready_in;
  // A full accumulator may still pop when it is being emptied into the
  // output register this cycle: that event starts the next batch, which
  // keeps one-event-per-cycle throughput across batch boundaries.
  assign pop      = !rst && !bus.empty_in && (!full || out_free);

  assign flush_cond = full ||
                      ((accum_q != '0) && (bus.flush_in || flush_pend_q || timeout_hit));
  assign transfer   = flush_cond && out_free;

`ifdef KANAGAWA_EVENT_BATCH_DRAIN_TIMEOUT_EN
  kanagawa_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_in  (pop || transfer),
    .en_in   ((accum_q != '0) && !pop),
    .hit_out (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next accumulator, output register and pending-flush state.
  always_comb begin
    accum_d      = accum_q;
    count_d      = count_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    if (transfer) begin
      count_d      = accum_q;
      valid_d      = 1'b1;
      accum_d      = COUNT_WIDTH'(pop);
      flush_pend_d = 1'b0;
    end else begin
      accum_d = accum_q + COUNT_WIDTH'(pop);
      if (valid_q && bus.ready_in) begin
        valid_d = 1'b0;
      end
      // A flush with nothing accumulated is dropped on purpose.
      if (bus.flush_in && (accum_q != '0)) begin
        flush_pend_d = 1'b1;
      end
    end
  end

  // State registers; reset discards any accumulated or unaccepted batch.
  always_ff @(posedge clk) begin
    if (rst) begin
      accum_q      <= '0;
      count_q      <= '0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      accum_q      <= accum_d;
      count_q      <= count_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign bus.rdreq_out = pop;
  assign bus.valid_out = valid_q;
  assign bus.count_out = count_q;
  assign bus.busy_out  = (accum_q != '0) || valid_q;
endmodule
